// File: rtl/fir_output_decimator_pkg.sv
// fir_pkg: shared FIR widths, DC gain and saturation limits for the output path.
package fir_pkg;
    localparam int N2_DEF = 16;
    localparam int N3_DEF = 32;
    localparam int FIR_DC_GAIN = 128;
    localparam int SHIFT_DEF = $clog2(FIR_DC_GAIN);

    function automatic longint sat_max(input int n2);
        return (longint'(1) <<< (n2 - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int n2);
        return -(longint'(1) <<< (n2 - 1));
    endfunction
endpackage

// File: rtl/fir_output_decimator_sample_fifo.sv
// sample_fifo: show-ahead FIFO; a push into a full FIFO is accepted only alongside a pop.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;

    assign empty = level == '0;
    assign full = level == (AW+1)'(DEPTH);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = empty ? '0 : mem[rptr];

    always_ff @(posedge CLK) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            if (do_push != do_pop) level <= do_push ? level + 1'b1 : level - 1'b1;
        end
    end
endmodule

// File: rtl/fir_output_decimator.sv
// fir_output_decimator: round, scale and saturate FIR accumulator output, decimate,
// and buffer kept samples for a valid/ready consumer.
module fir_output_decimator
    import fir_pkg::*;
#(
    parameter int N2 = N2_DEF,
    parameter int N3 = N3_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int DECIM = 4,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N3-1:0]            in_data,
    input  logic                     in_valid,
    output logic [N2-1:0]            out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     clipped
);
    localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
    localparam logic signed [N3:0] RND = (N3+1)'(longint'(1) <<< (SHIFT - 1));
    localparam logic signed [N3:0] HI = (N3+1)'(sat_max(N2));
    localparam logic signed [N3:0] LO = (N3+1)'(sat_min(N2));

    logic [PW-1:0] phase;
    logic s1_valid;
    logic signed [N3:0] sum, s1_r;
    logic hi, lo, full, empty;
    logic [N2-1:0] sat;

    // One guard bit keeps the rounding add from wrapping near full scale.
    assign sum = $signed({in_data[N3-1], in_data}) + RND;
    assign hi = s1_r > HI;
    assign lo = s1_r < LO;
    assign sat = hi ? HI[N2-1:0] : lo ? LO[N2-1:0] : s1_r[N2-1:0];
    assign out_valid = !empty;

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase <= '0;
            s1_valid <= 1'b0;
            s1_r <= '0;
            overflow <= 1'b0;
            clipped <= 1'b0;
        end else begin
            if (in_valid) phase <= phase == PW'(DECIM - 1) ? '0 : phase + 1'b1;
            s1_valid <= in_valid && phase == '0;
            s1_r <= sum >>> SHIFT;
            if (s1_valid && full && !out_ready) overflow <= 1'b1;
            if (s1_valid && (hi || lo)) clipped <= 1'b1;
        end
    end

    sample_fifo #(.WIDTH(N2), .DEPTH(DEPTH)) u_fifo (
        .CLK(CLK),
        .RST(RST),
        .push(s1_valid),
        .pop(out_ready),
        .din(sat),
        .dout(out_data),
        .empty(empty),
        .full(full),
        .level(level)
    );
endmodule

// File: tb/tb_fir_output_decimator.sv
// tb_fir_output_decimator: DECIM=1 and DECIM=4 instances on shared stimulus,
// checked each cycle against a queue-based reference model plus directed cases.
module tb_fir_output_decimator;
    logic CLK = 0, RST = 1, in_valid = 0, out_ready = 1;
    logic [31:0] in_data = '0;
    logic [15:0] od [2];
    logic [2:0] lv [2];
    logic ov [2], of [2], cl [2];
    int vectors = 0, miscompares = 0;

    always #5 CLK = ~CLK;

    fir_output_decimator #(.DECIM(1)) u_d1 (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .level(lv[0]), .overflow(of[0]), .clipped(cl[0])
    );

    fir_output_decimator #(.DECIM(4)) u_d4 (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .level(lv[1]), .overflow(of[1]), .clipped(cl[1])
    );

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: scale by 1/128 with round-half-up, clamp, keep every DECIM-th valid sample.
    function automatic int ref_sample(input logic [31:0] x, output bit c);
        longint r;
        r = (longint'($signed(x)) + 64) >>> 7;
        c = r > 32767 || r < -32768;
        return r > 32767 ? 32767 : r < -32768 ? -32768 : int'(r);
    endfunction

    int mq [2][$];
    int cnt [2];
    int pval [2];
    bit pend [2], pclip [2], mov [2], mcl [2];
    bit armed = 0;
    int sz;
    bit pp;

    always @(posedge CLK) begin
        armed = 1;
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                mq[i].delete();
                cnt[i] = 0;
                pend[i] = 0;
                mov[i] = 0;
                mcl[i] = 0;
            end else begin
                sz = mq[i].size();
                pp = sz > 0 && out_ready;
                if (pp) void'(mq[i].pop_front());
                if (pend[i]) begin
                    mcl[i] |= pclip[i];
                    if (sz < 4 || pp) mq[i].push_back(pval[i]);
                    else mov[i] = 1;
                end
                pend[i] = in_valid && (cnt[i] % (i == 0 ? 1 : 4)) == 0;
                if (in_valid) cnt[i]++;
                pval[i] = ref_sample(in_data, pclip[i]);
            end
        end
    end

    always @(negedge CLK) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("d%0d.out_valid", i * 3 + 1), ov[i], mq[i].size() > 0);
                check($sformatf("d%0d.out_data", i * 3 + 1), $signed(od[i]), mq[i].size() > 0 ? mq[i][0] : 0);
                check($sformatf("d%0d.level", i * 3 + 1), lv[i], mq[i].size());
                check($sformatf("d%0d.overflow", i * 3 + 1), of[i], mov[i]);
                check($sformatf("d%0d.clipped", i * 3 + 1), cl[i], mcl[i]);
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int v);
        in_valid = 1;
        in_data = v;
        tick();
        in_valid = 0;
    endtask

    task automatic reset_all;
        RST = 1;
        tick();
        RST = 0;
    endtask

    int rin [4] = '{64, 63, -64, -65};
    int rexp [4] = '{1, 0, 0, -1};
    int sel, rp;

    initial begin
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            check("rst.out_valid", ov[i], 0);
            check("rst.out_data", $signed(od[i]), 0);
            check("rst.level", lv[i], 0);
            check("rst.overflow", of[i], 0);
            check("rst.clipped", cl[i], 0);
        end
        RST = 0;
        send(128000);
        check("gain.early_valid", ov[0], 0);
        tick();
        check("gain.valid", ov[0], 1);
        check("gain.data", $signed(od[0]), 1000);
        repeat (4) tick();
        out_ready = 0;
        for (int k = 0; k < 4; k++) send(rin[k]);
        tick();
        check("round.level", lv[0], 4);
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("round.data%0d", k), $signed(od[0]), rexp[k]);
            tick();
        end
        check("round.clipped", cl[0], 0);
        send(5120000);
        tick();
        check("sat.max", $signed(od[0]), 32767);
        check("sat.clip1", cl[0], 1);
        tick();
        send(-5000000);
        tick();
        check("sat.min", $signed(od[0]), -32768);
        check("sat.clip2", cl[0], 1);
        tick();
        reset_all();
        out_ready = 0;
        for (int k = 0; k < 8; k++) begin
            send(128 * k);
            if (k == 2) repeat (3) tick();
        end
        tick();
        check("decim.level", lv[1], 2);
        check("decim.data0", $signed(od[1]), 0);
        out_ready = 1;
        tick();
        check("decim.data1", $signed(od[1]), 4);
        tick();
        check("decim.empty", ov[1], 0);
        reset_all();
        out_ready = 0;
        for (int k = 1; k <= 6; k++) send(128 * k);
        tick();
        check("full.level", lv[0], 4);
        check("full.overflow", of[0], 1);
        out_ready = 1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("full.pop%0d", k), $signed(od[0]), k);
            tick();
        end
        reset_all();
        out_ready = 0;
        for (int k = 1; k <= 4; k++) send(128 * k);
        tick();
        check("pp.level_before", lv[0], 4);
        in_valid = 1;
        in_data = 9 * 128;
        tick();
        in_valid = 0;
        out_ready = 1;
        tick();
        out_ready = 0;
        check("pp.level", lv[0], 4);
        check("pp.overflow", of[0], 0);
        check("pp.head", $signed(od[0]), 2);
        out_ready = 1;
        in_valid = 1;
        in_data = 7 * 128;
        tick();
        RST = 1;
        in_data = 8 * 128;
        tick();
        RST = 0;
        in_valid = 0;
        check("midrst.out_valid", ov[0], 0);
        check("midrst.level", lv[0], 0);
        repeat (3) tick();
        check("midrst.no_stale", ov[0], 0);
        rp = 2;
        for (int n = 0; n < 3000; n++) begin
            if (n % 100 == 0) rp = $urandom_range(0, 4);
            RST = $urandom_range(0, 199) == 0;
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) < rp;
            sel = $urandom_range(0, 2);
            in_data = sel == 0 ? $urandom :
                      sel == 1 ? 32'($urandom_range(0, 8388607)) - 32'd4194304 :
                      32'($urandom_range(0, 600)) * 32'd128 - 32'd38400 + 32'd63 + 32'($urandom_range(0, 1));
            tick();
        end
        RST = 0;
        in_valid = 0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fir_output_decimator.md
# fir_output_decimator

Receives the registered output stream of the 8-tap FIR filter and converts it back to sample width. It rounds, scales and saturates each 32-bit accumulator value to 16 bits, then keeps one of every DECIM samples. Kept samples are buffered in a small FIFO and delivered to the downstream consumer over a valid/ready handshake. It sits directly after the FIR: `in_valid` is the FIR's ENABLE delayed by one cycle, to match the FIR's registered output.

## Interface
- `N2`, 16: output sample width.
- `N3`, 32: input (FIR accumulator) width.
- `SHIFT`, 7: right-shift applied to the accumulator; 7 removes the FIR DC gain of 8 × 16 = 128. Legal range 1..N3-N2.
- `DECIM`, 4: decimation factor; 1 disables decimation.
- `DEPTH`, 4: FIFO depth in entries; must be a power of 2, at least 2.

Ports (clock and reset first):
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `in_data` in N3: signed FIR output.
- `in_valid` in 1: `in_data` is a new sample this cycle. There is no backpressure toward the FIR.
- `out_data` out N2: signed head of FIFO.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accepts `out_data` this cycle.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.
- `overflow` out 1: sticky; a kept sample was dropped because the FIFO was full.
- `clipped` out 1: sticky; at least one kept sample saturated.

## Operation
- Phase counter runs 0..DECIM-1.
  - Advances only on `in_valid`; wraps to 0.
  - A sample is kept only when `in_valid` is high and phase is 0.
  - The first valid sample after reset is therefore kept.
- Stage 1 registers the keep decision and the rounded value.
  - Computed in N3+1 bits: r = (in_data + 2^(SHIFT-1)) >>> SHIFT.
  - Arithmetic shift, so rounding is half toward +infinity.
- Stage 2 saturates and writes the FIFO.
  - If r > 2^(N2-1)-1, the result is 2^(N2-1)-1; if r < -2^(N2-1), the result is -2^(N2-1). Otherwise the result is r truncated to N2 bits.
  - Any saturation sets `clipped`.
- FIFO is show-ahead: `out_data` is valid whenever `out_valid` is high.
  - A pop occurs when `out_valid` and `out_ready` are both high.
- Write acceptance: a write is accepted when not full, or when full and a pop occurs in the same cycle. Otherwise the sample is discarded and `overflow` is set.
- Simultaneous push and pop leave `level` unchanged. Read and write pointers wrap modulo DEPTH.
- Pop while empty has no effect.
- `out_data` holds its value while `out_valid` is high and `out_ready` is low.
- `overflow` and `clipped` clear only on RST.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `level` = 0, `overflow` = 0, `clipped` = 0.
  - Phase = 0 and both stage-valid bits = 0.
- RST mid-operation discards everything in flight: both stage registers and all FIFO contents. Samples presented during the reset cycle are ignored.
- Latency with the FIFO empty: a kept sample presented in cycle 0 appears with `out_valid`=1 in cycle 2.
- Throughput: one kept sample per cycle (DECIM=1, `out_ready` held high).
- `level` and `out_valid` update on the clock edge following a push or pop. There are no combinational paths from `in_*` to `out_*`.
- `out_valid` must not depend combinationally on `out_ready`.

## Structure
- Shared package `fir_pkg`: N2/N3 defaults, SAT_MAX/SAT_MIN constant functions of N2, and the FIR DC-gain constant (128) from which SHIFT's default derives.
- One sub-module, `sample_fifo`, parameterised by width and DEPTH.
  - Ports: push, pop, din, dout, empty, full, level.
  - Owns the pointers and the simultaneous push/pop rule.
- The phase counter, round/saturate pipeline and sticky flags live in the top module.

## Test plan
- Gain check (DECIM=1, `out_ready`=1): `in_data`=128000 for one cycle → `out_data`=1000 with `out_valid` in cycle 2.
- Rounding (DECIM=1):
  - Inputs 64, 63, -64 and -65 → outputs 1, 0, 0 and -1.
  - `clipped` stays 0 throughout.
- Saturation: input 5120000 → 32767; input -5000000 → -32768; `clipped`=1 after the first and remains set.
- Decimation (DECIM=4): inputs 128×k for k=0..7, with a 3-cycle `in_valid` gap after k=2 → outputs exactly 0 and 4; the gap does not advance the phase.
- Full FIFO: `out_ready`=0 and 6 kept samples 1..6 → `level`=4 and `overflow`=1. Then `out_ready`=1 → pops 1, 2, 3, 4 in order.
- Full with simultaneous push and pop: FIFO full, push 9 in the same cycle as a pop → `level` stays 4 and `overflow` unchanged. Then assert RST mid-stream → `out_valid`=0 and `level`=0 the next cycle, and no stale sample appears afterwards.
